// File: rtl/eth_pkg.sv
// Shared Ethernet RX constants, state type and CRC-32 helpers.
package eth_pkg;

   localparam int unsigned ETH_HDR_LEN = 14;
   localparam int unsigned ETH_FCS_LEN = 4;
   localparam int unsigned ETH_MIN_LEN = ETH_HDR_LEN + ETH_FCS_LEN;

   localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   // Residue of the running register after the FCS, in non-reflected bit order.
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

   typedef enum logic [2:0] {StIdle, StHdr, StPayload, StCommit, StDrop} rx_state_e;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // One byte of the reflected (LSB-first) CRC-32 update.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ bitrev32(CRC32_POLY)) : (c >> 1);
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise reflected CRC-32. o_crc includes the byte presented this cycle when i_en=1,
// so the caller can test the residue on the eof byte itself.
module eth_crc32
   import eth_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_init,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] crc_q, crc_d;

   // Next CRC: init seeds with all-ones, and may be combined with the first byte.
   always_comb begin
      crc_d = crc_q;
      if (i_en)        crc_d = crc32_byte(i_init ? 32'hFFFF_FFFF : crc_q, i_data);
      else if (i_init) crc_d = 32'hFFFF_FFFF;
   end

   // CRC register.
   always_ff @(posedge i_clk) begin
      if (i_rst) crc_q <= 32'hFFFF_FFFF;
      else       crc_q <= crc_d;
   end

   assign o_crc = crc_d;

endmodule

// File: rtl/eth_rx_payload_fifo.sv
// Ethernet RX header filter + FCS strip feeding a frame-atomic show-ahead byte FIFO.
// Optional FCS check: define ETH_RX_FCS_CHECK_EN.
module eth_rx_payload_fifo
   import eth_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
   parameter bit          PROMISC = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_rx_sof,
   input  logic              i_rx_eof,
   input  logic              i_rx_err,
   output logic [7:0]        o_rdata,
   output logic              o_rready,
   input  logic              i_rreq,
   output logic [ADDR_W:0]   o_level,
   output logic [15:0]       o_drop_cnt
);

   localparam int unsigned DEPTH    = 2**ADDR_W;
   localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LEN - 1);
   localparam logic [3:0]  DST_LAST = 4'd5;

   logic [7:0]      mem [DEPTH];
   rx_state_e       state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [39:0]     dst_q, dst_d;      // first five destination bytes
   logic [7:0]      dl_q [4];          // FCS-strip delay line, dl_q[3] oldest
   logic [7:0]      dl_d [4];
   logic [2:0]      dl_cnt_q, dl_cnt_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, wr_spec_q, wr_spec_d, rd_ptr_q, rd_ptr_d, spec_nxt;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            sof_byte, restart, pay_byte, need_wr, full, wr_en, commit, drop_evt;
   logic            dst_hit, short_frm, crc_bad, pop;

   assign sof_byte  = i_rx_valid & i_rx_sof;
   assign restart   = sof_byte & ((state_q == StHdr) | (state_q == StPayload));
   assign pay_byte  = (state_q == StPayload) & i_rx_valid & ~i_rx_sof & ~i_rx_err;
   assign need_wr   = pay_byte & (dl_cnt_q == 3'd4);
   assign spec_nxt  = wr_spec_q + 1'b1;
   assign full      = (spec_nxt[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &
                      (spec_nxt[ADDR_W] != rd_ptr_q[ADDR_W]);
   assign wr_en     = need_wr & ~full;
   assign dst_hit   = PROMISC | ({dst_q, i_rx_data} == MY_MAC) | ({dst_q, i_rx_data} == BCAST_MAC);
   // Fewer than four bytes after the header, counting the eof byte itself.
   assign short_frm = dl_cnt_q < 3'(ETH_FCS_LEN - 1);
   assign pop       = i_rreq & o_rready;

`ifdef ETH_RX_FCS_CHECK_EN
   logic [31:0] crc_run;

   eth_crc32 u_crc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_init (sof_byte),
      .i_en   (i_rx_valid & (sof_byte | (state_q == StHdr) | (state_q == StPayload))),
      .i_data (i_rx_data),
      .o_crc  (crc_run)
   );

   assign crc_bad = bitrev32(crc_run) != CRC32_RESIDUE;
`else
   assign crc_bad = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next state: a sof is accepted from any state; a sof mid-frame restarts in the header.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StCommit, StDrop: begin
            state_d = StIdle;
            if (sof_byte) state_d = (i_rx_err | i_rx_eof) ? StDrop : StHdr;
         end
         StHdr: begin
            if (sof_byte)                                   state_d = (i_rx_err | i_rx_eof) ? StDrop : StHdr;
            else if (i_rx_err)                              state_d = StDrop;
            else if (i_rx_valid) begin
               if (i_rx_eof)                                state_d = StDrop;
               else if ((cnt_q == DST_LAST) && !dst_hit)    state_d = StDrop;
               else if (cnt_q == HDR_LAST)                  state_d = StPayload;
            end
         end
         StPayload: begin
            if (sof_byte)                                   state_d = (i_rx_err | i_rx_eof) ? StDrop : StHdr;
            else if (i_rx_err)                              state_d = StDrop;
            else if (i_rx_valid) begin
               if (i_rx_eof)
                  state_d = (short_frm | (need_wr & full) | crc_bad) ? StDrop : StCommit;
               else if (need_wr & full)                     state_d = StDrop;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath controls: header capture, delay line, pointers and drop counter.
   always_comb begin
      commit     = state_q == StCommit;
      drop_evt   = (state_q == StDrop) | restart;
      cnt_d      = cnt_q;
      dst_d      = dst_q;
      dl_d       = dl_q;
      dl_cnt_d   = dl_cnt_q;
      if (sof_byte) begin
         cnt_d    = 4'd1;
         dst_d    = {dst_q[31:0], i_rx_data};
         dl_cnt_d = 3'd0;
      end else if ((state_q == StHdr) && i_rx_valid) begin
         cnt_d = cnt_q + 4'd1;
         dst_d = {dst_q[31:0], i_rx_data};
      end else if (pay_byte) begin
         dl_d[0] = i_rx_data;
         for (int i = 1; i < 4; i++) dl_d[i] = dl_q[i-1];
         if (dl_cnt_q != 3'd4) dl_cnt_d = dl_cnt_q + 3'd1;
      end
      wr_spec_d = wr_spec_q;
      if (drop_evt)   wr_spec_d = wr_ptr_q;
      else if (wr_en) wr_spec_d = spec_nxt;
      wr_ptr_d   = commit ? wr_spec_q : wr_ptr_q;
      rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
      drop_cnt_d = drop_cnt_q;
      if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // Control and pointer registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q      <= '0;
         dst_q      <= '0;
         dl_q       <= '{default: '0};
         dl_cnt_q   <= '0;
         wr_ptr_q   <= '0;
         wr_spec_q  <= '0;
         rd_ptr_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         dst_q      <= dst_d;
         dl_q       <= dl_d;
         dl_cnt_q   <= dl_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_spec_q  <= wr_spec_d;
         rd_ptr_q   <= rd_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage write port; the byte leaving the delay line is the one stored.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_spec_q[ADDR_W-1:0]] <= dl_q[3];
   end

   assign o_rready   = wr_ptr_q != rd_ptr_q;
   assign o_rdata    = o_rready ? mem[rd_ptr_q[ADDR_W-1:0]] : 8'h00;
   assign o_level    = wr_ptr_q - rd_ptr_q;
   assign o_drop_cnt = drop_cnt_q;

endmodule
